// File: rtl/note_sequencer.sv
// note_sequencer: plays a stored melody by driving the signal generator's frequency input.
// Latency: start sampled on edge t -> first note visible from edge t+1; all outputs registered.
// Flow: no backpressure; stop aborts in one cycle, start while busy or with load_en is ignored.
//
// Ports:
//   CLK_32KHz        sample clock (only clock)
//   reset            synchronous, active-high
//   load_en/addr/
//   freq/dur         song table write port (usable at any time, including during playback)
//   start/stop       begin playback from entry 0 / abort playback
//   loop_en          at end of song, restart from entry 0 instead of finishing
//   outputFrequency  frequency to the generator (clamped to 8000 Hz), 0 during gaps/rests/idle
//   noteActive       high while a non-rest note sounds
//   noteIndex        current table entry
//   busy             high while playing
//   songDone         one-cycle pulse on normal completion
module note_sequencer #(
   parameter int SONG_LENGTH    = 16,
   parameter int TICKS_PER_UNIT = 3200,
   parameter int GAP_TICKS      = 320
) (
   input  logic                           CLK_32KHz,
   input  logic                           reset,
   input  logic                           load_en,
   input  logic [$clog2(SONG_LENGTH)-1:0] load_addr,
   input  logic [13:0]                    load_freq,
   input  logic [3:0]                     load_dur,
   input  logic                           start,
   input  logic                           stop,
   input  logic                           loop_en,
   output logic [13:0]                    outputFrequency,
   output logic                           noteActive,
   output logic [$clog2(SONG_LENGTH)-1:0] noteIndex,
   output logic                           busy,
   output logic                           songDone
);

   localparam int          AW       = $clog2(SONG_LENGTH);
   localparam logic [19:0] TPU20    = 20'(TICKS_PER_UNIT);
   localparam bit          NO_GAP   = (GAP_TICKS == 0);
   localparam logic [15:0] GAP_M1   = (GAP_TICKS > 0) ? 16'(GAP_TICKS - 1) : 16'd0;
   localparam logic [13:0] FREQ_MAX = 14'd8000;

   typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;

   // Song table; deliberately not reset so a reset keeps the loaded melody.
   logic [13:0] freq_mem [SONG_LENGTH];
   logic [3:0]  dur_mem  [SONG_LENGTH];

   state_t          state_q;
   logic [13:0]     freq_q;
   logic            active_q;
   logic [AW-1:0]   idx_q;
   logic            busy_q;
   logic            done_q;
   logic [19:0]     dur_cnt_q;   // 15 x 65535 needs 20 bits
   logic [15:0]     gap_cnt_q;

   logic [AW-1:0]   next_idx_d;
   logic [AW-1:0]   tgt_idx_d;
   logic            end_of_song;
   logic            at_boundary;
   logic            idle_start;
   logic [13:0]     tgt_freq;
   logic [3:0]      tgt_dur;
   logic            tgt_empty;
   logic [13:0]     tgt_freq_clamped;
   logic [19:0]     tgt_ticks_m1;
   logic            go_enter;
   logic            go_finish;

   always_ff @(posedge CLK_32KHz) begin
      if (load_en) begin
         freq_mem[load_addr] <= load_freq;
         dur_mem[load_addr]  <= load_dur;
      end
   end

   always_comb begin
      // Table size is a power of two, so the increment wraps last -> 0 on its own.
      next_idx_d  = idx_q + 1'b1;
      end_of_song = (&idx_q) || (dur_mem[next_idx_d] == 4'd0);

      // Cycle in which a note (with no gap) or a gap has run out and we must advance.
      at_boundary = ((state_q == S_NOTE) && (dur_cnt_q == 20'd0) && NO_GAP) ||
                    ((state_q == S_GAP)  && (gap_cnt_q == 16'd0));
      idle_start  = (state_q == S_IDLE) && start && !load_en;

      // Entry we would enter next: 0 from idle or when wrapping at end of song.
      tgt_idx_d        = ((state_q == S_IDLE) || end_of_song) ? '0 : next_idx_d;
      tgt_freq         = freq_mem[tgt_idx_d];
      tgt_dur          = dur_mem[tgt_idx_d];
      tgt_empty        = (tgt_dur == 4'd0);
      tgt_freq_clamped = (tgt_freq > FREQ_MAX) ? FREQ_MAX : tgt_freq;
      tgt_ticks_m1     = 20'(tgt_dur) * TPU20 - 20'd1;

      // Finishing covers: empty song on start, end of song without loop,
      // and a loop request whose entry 0 is itself the end marker.
      go_finish = (idle_start && tgt_empty) ||
                  (at_boundary && ((end_of_song && !loop_en) || tgt_empty));
      go_enter  = (idle_start || at_boundary) && !go_finish;
   end

   always_ff @(posedge CLK_32KHz) begin
      // stop behaves exactly like reset on the sequencer state: idle, all zero, no songDone.
      if (reset || stop) begin
         state_q   <= S_IDLE;
         freq_q    <= '0;
         active_q  <= 1'b0;
         idx_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dur_cnt_q <= '0;
         gap_cnt_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (go_enter) begin
            state_q   <= S_NOTE;
            idx_q     <= tgt_idx_d;
            freq_q    <= tgt_freq_clamped;
            active_q  <= (tgt_freq != 14'd0);
            busy_q    <= 1'b1;
            dur_cnt_q <= tgt_ticks_m1;
         end else if (go_finish) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            freq_q   <= '0;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
         end else begin
            case (state_q)
               S_NOTE: begin
                  // A zero count here only happens with a gap configured;
                  // the no-gap case is handled as a boundary above.
                  if (dur_cnt_q == 20'd0) begin
                     state_q   <= S_GAP;
                     freq_q    <= '0;
                     active_q  <= 1'b0;
                     gap_cnt_q <= GAP_M1;
                  end else begin
                     dur_cnt_q <= dur_cnt_q - 20'd1;
                  end
               end
               S_GAP: begin
                  if (gap_cnt_q != 16'd0) begin
                     gap_cnt_q <= gap_cnt_q - 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign outputFrequency = freq_q;
   assign noteActive      = active_q;
   assign noteIndex       = idx_q;
   assign busy            = busy_q;
   assign songDone        = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: expected per-cycle traces are built from the song table
// (each entry = dur*TPU note cycles + GAP gap cycles, then a done pulse) and compared
// against the outputs one cycle at a time, in directed and randomized scenarios.
module tb_note_sequencer;

   localparam int SL  = 4;
   localparam int TPU = 4;
   localparam int GAP = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_en;
   logic [1:0]  load_addr;
   logic [13:0] load_freq;
   logic [3:0]  load_dur;
   logic        start;
   logic        stop;
   logic        loop_en;
   logic [13:0] outputFrequency;
   logic        noteActive;
   logic [1:0]  noteIndex;
   logic        busy;
   logic        songDone;

   always #5 clk = ~clk;

   note_sequencer #(
      .SONG_LENGTH   (SL),
      .TICKS_PER_UNIT(TPU),
      .GAP_TICKS     (GAP)
   ) dut (
      .CLK_32KHz      (clk),
      .reset          (reset),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_freq      (load_freq),
      .load_dur       (load_dur),
      .start          (start),
      .stop           (stop),
      .loop_en        (loop_en),
      .outputFrequency(outputFrequency),
      .noteActive     (noteActive),
      .noteIndex      (noteIndex),
      .busy           (busy),
      .songDone       (songDone)
   );

   typedef struct packed {
      logic [13:0] f;
      logic        a;
      logic [1:0]  i;
      logic        b;
      logic        d;
   } smp_t;

   smp_t exp_q[$];
   int   last_start;
   int   m_freq[SL];
   int   m_dur[SL];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] obs();
      return 32'({outputFrequency, noteActive, noteIndex, busy, songDone});
   endfunction

   function automatic smp_t mk(input int f, input int a, input int i, input int b, input int d);
      smp_t s;
      s.f = 14'(f);
      s.a = a[0];
      s.i = 2'(i);
      s.b = b[0];
      s.d = d[0];
      return s;
   endfunction

   function automatic int clamp(input int f);
      return (f > 8000) ? 8000 : f;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_entry(input int a, input int f, input int d);
      load_en   = 1'b1;
      load_addr = 2'(a);
      load_freq = 14'(f);
      load_dur  = 4'(d);
      step();
      load_en   = 1'b0;
      m_freq[a] = f;
      m_dur[a]  = d;
      check("idle_while_loading", obs(), 32'd0);
   endtask

   // Expected trace for `passes` traversals of the table (looping between them),
   // followed by the done pulse and one idle cycle.
   task automatic build(input int passes);
      exp_q.delete();
      last_start = 0;
      for (int p = 0; p < passes; p++) begin
         if (p == passes - 1) last_start = exp_q.size();
         if (m_dur[0] == 0) break;
         for (int i = 0; i < SL; i++) begin
            repeat (m_dur[i] * TPU) exp_q.push_back(mk(clamp(m_freq[i]), int'(m_freq[i] != 0), i, 1, 0));
            repeat (GAP) exp_q.push_back(mk(0, 0, i, 1, 0));
            if (i == SL - 1 || m_dur[i + 1] == 0) break;
         end
      end
      exp_q.push_back(mk(0, 0, 0, 0, 1));
      exp_q.push_back(mk(0, 0, 0, 0, 0));
   endtask

   // stop_at / bs_at of -2 mean "pick a random cycle"; -1 means "never".
   task automatic play(input string name, input int passes, input int stop_at, input int rst_at,
                       input int ovr_at, input int ovr_a, input int ovr_f, input int ovr_d,
                       input int bs_at);
      if (ovr_at >= 0) begin
         m_freq[ovr_a] = ovr_f;
         m_dur[ovr_a]  = ovr_d;
      end
      build(passes);
      if (stop_at == -2) stop_at = $urandom_range(1, exp_q.size() - 1);
      if (bs_at == -2) bs_at = (exp_q.size() >= 3) ? $urandom_range(1, exp_q.size() - 2) : -1;
      for (int k = 0; k < exp_q.size(); k++) begin
         start     = (k == 0) || (k == bs_at && k < exp_q.size() - 1);
         stop      = (k == stop_at);
         reset     = (k == rst_at);
         loop_en   = (k <= last_start);
         load_en   = (k == ovr_at);
         load_addr = 2'(ovr_a);
         load_freq = 14'(ovr_f);
         load_dur  = 4'(ovr_d);
         step();
         if (k == stop_at || k == rst_at) begin
            check($sformatf("%s_abort_c%0d", name, k), obs(), 32'd0);
            break;
         end
         check($sformatf("%s_c%0d", name, k), obs(), 32'(exp_q[k]));
      end
      start   = 1'b0;
      stop    = 1'b0;
      reset   = 1'b0;
      loop_en = 1'b0;
      load_en = 1'b0;
      step();
      check($sformatf("%s_idle", name), obs(), 32'd0);
   endtask

   task automatic basic_table();
      write_entry(0, 440, 1);
      write_entry(1, 880, 2);
      write_entry(2, 0, 1);
      write_entry(3, 123, 0);
   endtask

   initial begin
      reset = 1'b1; load_en = 1'b0; load_addr = '0; load_freq = '0; load_dur = '0;
      start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      step();
      step();
      check("reset_state", obs(), 32'd0);
      reset = 1'b0;

      basic_table();
      play("basic", 1, -1, -1, -1, 0, 0, 0, 3);

      write_entry(0, 9000, 1);
      write_entry(1, 100, 1);
      write_entry(2, 200, 1);
      write_entry(3, 300, 1);
      play("clamp", 1, -1, -1, -1, 0, 0, 0, -1);

      basic_table();
      play("loop", 3, -1, -1, -1, 0, 0, 0, -1);
      play("stop_note", 1, 2, -1, -1, 0, 0, 0, -1);

      start = 1'b1; stop = 1'b1;
      step();
      check("start_stop", obs(), 32'd0);
      start = 1'b0; stop = 1'b0;
      step();
      check("start_stop_after", obs(), 32'd0);

      start = 1'b1; load_en = 1'b1; load_addr = 2'd3; load_freq = 14'd123; load_dur = 4'd0;
      step();
      check("start_load", obs(), 32'd0);
      start = 1'b0; load_en = 1'b0;
      step();
      check("start_load_after", obs(), 32'd0);

      write_entry(0, 440, 0);
      play("empty", 1, -1, -1, -1, 0, 0, 0, -1);
      write_entry(0, 440, 1);

      play("overwrite", 1, -1, -1, 1, 1, 1234, 3, -1);

      basic_table();
      play("reset_gap", 1, -1, 5, -1, 0, 0, 0, -1);
      play("after_reset", 1, -1, -1, -1, 0, 0, 0, -1);

      for (int it = 0; it < 25; it++) begin
         for (int a = 0; a < SL; a++) begin
            int f;
            f = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 16383));
            write_entry(a, f, int'($urandom_range(0, 4)));
         end
         play($sformatf("rnd%0d", it), int'($urandom_range(1, 3)),
              ($urandom_range(0, 3) == 0) ? -2 : -1, -1, -1, 0, 0, 0,
              ($urandom_range(0, 1) == 0) ? -2 : -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
